ips_dbc_trigger_input: RTL and testbench

Debug-core trigger input stage, the receive-side counterpart of the trigger output block. It accepts an asynchronous external trigger (cross-core or pin), synchronizes and glitch-filters it, and applies a JTAG-configured polarity, enable and edge/level mode. It presents the result as `trig_hit` to the core's trigger-condition logic. Its configuration word is loaded through the shared debug config shift chain and read back through the shared read chain.

---
 rtl/ips_dbc_trigger_input.sv | 114 +++++++++++
 tb/tb_ips_dbc_trigger_input.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ips_dbc_trigger_input.sv
// Debug-core trigger input: synchronizes and glitch-filters an external trigger, then applies
// a JTAG-loaded enable/polarity/mode word to produce a registered trig_hit.
module ips_dbc_trigger_input #(
    parameter int         TRIG_IN_CHAIN_BIT = 4,
    parameter logic [3:0] INIT_TRIG_IN      = 4'b1001,
    parameter int         SYNC_STAGES       = 2,
    parameter int         FILTER_CYC        = 1,
    parameter logic [4:0] CONF_ID           = 5'd0
) (
    input  logic       clk_trig,
    input  logic       rst_trig,
    input  logic       trig_in,
    input  logic       conf_sel,
    input  logic       shift_i,
    input  logic       conf_tdi,
    output logic       trig_hit,
    input  logic       conf_rden,
    input  logic [4:0] conf_id,
    input  logic       conf_sel_rd,
    output logic       conf_rdata,
    output logic       conf_rdlast
);

    localparam logic [7:0] LP_CNT_LAST = 8'(FILTER_CYC - 1);

    logic [SYNC_STAGES-1:0]       r_sync;
    logic                         r_filt;
    logic                         r_prev;
    logic [7:0]                   r_flt_cnt;
    logic                         r_trig_hit;
    logic [TRIG_IN_CHAIN_BIT-1:0] r_shreg;
    logic [TRIG_IN_CHAIN_BIT-1:0] r_cfg;
    logic                         r_sel_d;
    logic [1:0]                   r_rd_idx;

    logic       w_en;
    logic       w_inv;
    logic [1:0] w_mode;
    logic       w_s_pol;
    logic       w_rd_sel;

    assign w_en     = r_cfg[3];
    assign w_inv    = r_cfg[2];
    assign w_mode   = r_cfg[1:0];
    assign w_s_pol  = r_sync[SYNC_STAGES-1] ^ w_inv;
    assign w_rd_sel = conf_sel_rd && (conf_id == CONF_ID);

    // Config shift chain; the word goes live when conf_sel is released.
    always_ff @(posedge clk_trig or posedge rst_trig) begin
        if (rst_trig) begin
            r_shreg <= '0;
            r_sel_d <= 1'b0;
            r_cfg   <= INIT_TRIG_IN;
        end else begin
            r_sel_d <= conf_sel;
            if (conf_sel && shift_i)
                r_shreg <= {conf_tdi, r_shreg[TRIG_IN_CHAIN_BIT-1:1]};
            if (r_sel_d && !conf_sel)
                r_cfg <= r_shreg;
        end
    end

    always_ff @(posedge clk_trig or posedge rst_trig) begin
        if (rst_trig) begin
            r_sync    <= '0;
            r_filt    <= 1'b0;
            r_flt_cnt <= 8'd0;
            r_prev    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], trig_in};
            r_prev <= r_filt;
            if (w_s_pol == r_filt) begin
                r_flt_cnt <= 8'd0;
            end else if (r_flt_cnt == LP_CNT_LAST) begin
                r_filt    <= w_s_pol;
                r_flt_cnt <= 8'd0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 8'd1;
            end
        end
    end

    // Mode selects level, rising, falling or any-edge on the filtered level.
    always_ff @(posedge clk_trig or posedge rst_trig) begin
        if (rst_trig) begin
            r_trig_hit <= 1'b0;
        end else if (!w_en) begin
            r_trig_hit <= 1'b0;
        end else begin
            case (w_mode)
                2'b00:   r_trig_hit <= r_filt;
                2'b01:   r_trig_hit <= r_filt & ~r_prev;
                2'b10:   r_trig_hit <= ~r_filt & r_prev;
                default: r_trig_hit <= r_filt ^ r_prev;
            endcase
        end
    end

    // Read index 0 doubles as the idle state; dropping conf_sel_rd restarts at bit 0.
    always_ff @(posedge clk_trig or posedge rst_trig) begin
        if (rst_trig) begin
            r_rd_idx <= 2'd0;
        end else if (!conf_sel_rd) begin
            r_rd_idx <= 2'd0;
        end else if (w_rd_sel && conf_rden) begin
            r_rd_idx <= r_rd_idx + 2'd1;
        end
    end

    assign trig_hit    = r_trig_hit;
    assign conf_rdata  = w_rd_sel & r_cfg[r_rd_idx];
    assign conf_rdlast = w_rd_sel & (r_rd_idx == 2'd3);

endmodule

// File: tb/tb_ips_dbc_trigger_input.sv
// Bench for ips_dbc_trigger_input: a default instance and a FILTER_CYC=4 instance share all
// stimulus; both are compared every cycle with a history-based behavioural model.
`timescale 1ns/1ps
module tb_ips_dbc_trigger_input;

    localparam logic [3:0] INIT = 4'b1001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig_in = 1'b0, conf_sel = 1'b0, shift_i = 1'b0, conf_tdi = 1'b0;
    logic       conf_rden = 1'b0, conf_sel_rd = 1'b0;
    logic [4:0] conf_id = 5'd0;
    logic       hit0, hit1, rdata0, rdata1, rdlast0, rdlast1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ips_dbc_trigger_input u_dut0 (
        .clk_trig(clk), .rst_trig(rst), .trig_in(trig_in), .conf_sel(conf_sel),
        .shift_i(shift_i), .conf_tdi(conf_tdi), .trig_hit(hit0), .conf_rden(conf_rden),
        .conf_id(conf_id), .conf_sel_rd(conf_sel_rd), .conf_rdata(rdata0), .conf_rdlast(rdlast0)
    );

    ips_dbc_trigger_input #(.FILTER_CYC(4)) u_dut4 (
        .clk_trig(clk), .rst_trig(rst), .trig_in(trig_in), .conf_sel(conf_sel),
        .shift_i(shift_i), .conf_tdi(conf_tdi), .trig_hit(hit1), .conf_rden(conf_rden),
        .conf_id(conf_id), .conf_sel_rd(conf_sel_rd), .conf_rdata(rdata1), .conf_rdlast(rdlast1)
    );

    // Model histories, index = clock edge since reset release (index 0 = reset state).
    bit         tin_q[$];
    bit         sel_q[$];
    logic [3:0] cfg_q[$];
    bit         spol_q[$];
    bit         sh_q[$];
    bit         f0_q[$], f1_q[$], h0_q[$], h1_q[$];
    int         rd_cnt;

    typedef struct {
        logic [3:0] cfg;
        logic       tin;
        logic       exp_hit;
    } vec_t;
    vec_t tbl[9];

    logic [3:0] w, lb;
    int         c0, c1, run_left;
    int         pos0[$], pos1[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] shreg_val();
        logic [3:0] v;
        int sz;
        v = 4'b0000;
        sz = sh_q.size();
        for (int i = 0; i < 4; i++)
            if (sz - 1 - i >= 0) v[3-i] = sh_q[sz-1-i];
        return v;
    endfunction

    // New filtered level: flips only once the last f samples all agree on the new value.
    function automatic bit filt_next(input int f, input bit old);
        int n;
        bit v;
        n = spol_q.size() - 1;
        if (n < f) return old;
        v = spol_q[n];
        for (int j = n - f + 1; j <= n; j++)
            if (spol_q[j] != v) return old;
        return v;
    endfunction

    function automatic bit hit_calc(input logic [3:0] c, input bit cur, input bit prv);
        if (!c[3]) return 1'b0;
        case (c[1:0])
            2'b00:   return cur;
            2'b01:   return cur && !prv;
            2'b10:   return !cur && prv;
            default: return cur != prv;
        endcase
    endfunction

    task automatic model_reset();
        tin_q.delete(); sel_q.delete(); cfg_q.delete(); spol_q.delete(); sh_q.delete();
        f0_q.delete(); f1_q.delete(); h0_q.delete(); h1_q.delete();
        tin_q.push_back(1'b0); sel_q.push_back(1'b0); cfg_q.push_back(INIT);
        spol_q.push_back(1'b0); f0_q.push_back(1'b0); f1_q.push_back(1'b0);
        h0_q.push_back(1'b0); h1_q.push_back(1'b0);
        rd_cnt = 0;
    endtask

    task automatic model_step();
        int n;
        logic [3:0] cp, cn;
        bit sp, s_out;
        n  = tin_q.size();
        cp = cfg_q[n-1];
        cn = (sel_q[n-1] && !conf_sel) ? shreg_val() : cp;
        if (conf_sel && shift_i) sh_q.push_back(conf_tdi);
        s_out = (n - 1 >= 2) ? tin_q[n-2] : 1'b0;
        sp = s_out ^ cp[2];
        tin_q.push_back(trig_in); sel_q.push_back(conf_sel);
        cfg_q.push_back(cn); spol_q.push_back(sp);
        f0_q.push_back(filt_next(1, f0_q[n-1]));
        f1_q.push_back(filt_next(4, f1_q[n-1]));
        h0_q.push_back(hit_calc(cp, f0_q[n-1], (n >= 2) ? f0_q[n-2] : 1'b0));
        h1_q.push_back(hit_calc(cp, f1_q[n-1], (n >= 2) ? f1_q[n-2] : 1'b0));
        if (!conf_sel_rd) rd_cnt = 0;
        else if (conf_id == 5'd0 && conf_rden) rd_cnt = (rd_cnt + 1) % 4;
    endtask

    task automatic check_rd();
        bit sel;
        logic [3:0] cur;
        sel = conf_sel_rd && (conf_id == 5'd0);
        cur = cfg_q[$];
        chk("rdata0", int'(rdata0), sel ? int'(cur[rd_cnt]) : 0);
        chk("rdata1", int'(rdata1), sel ? int'(cur[rd_cnt]) : 0);
        chk("rdlast0", int'(rdlast0), int'(sel && rd_cnt == 3));
        chk("rdlast1", int'(rdlast1), int'(sel && rd_cnt == 3));
    endtask

    task automatic tick();
        #3;
        check_rd();
        model_step();
        @(posedge clk);
        #1;
        chk("hit0_model", int'(hit0), int'(h0_q[$]));
        chk("hit1_model", int'(hit1), int'(h1_q[$]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_hit0", int'(hit0), 0);
        chk("rst_hit1", int'(hit1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_bits(input int nb, input logic [7:0] bits);
        for (int i = 0; i < nb; i++) begin
            conf_sel = 1'b1; shift_i = 1'b1; conf_tdi = bits[i];
            tick();
        end
        conf_sel = 1'b0; shift_i = 1'b0; conf_tdi = 1'b0;
        tick();
    endtask

    task automatic read_word(output logic [3:0] wd, output logic [3:0] lst);
        conf_sel_rd = 1'b1; conf_id = 5'd0; conf_rden = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            wd[i]  = rdata0;
            lst[i] = rdlast0;
            tick();
        end
        conf_sel_rd = 1'b0; conf_rden = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t beyond limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{4'b1000, 1'b0, 1'b0};
        tbl[1] = '{4'b1000, 1'b1, 1'b1};
        tbl[2] = '{4'b1100, 1'b0, 1'b1};
        tbl[3] = '{4'b1100, 1'b1, 1'b0};
        tbl[4] = '{4'b0000, 1'b1, 1'b0};
        tbl[5] = '{4'b0100, 1'b0, 1'b0};
        tbl[6] = '{4'b1001, 1'b1, 1'b0};
        tbl[7] = '{4'b1110, 1'b1, 1'b0};
        tbl[8] = '{4'b1011, 1'b0, 1'b0};

        model_reset();
        do_reset();

        // Defaults: rising edge, single pulse 3 cycles after capture (6 with FILTER_CYC=4)
        trig_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("s1_hit0", int'(hit0), int'(i == 4));
            chk("s1_hit1", int'(hit1), int'(i == 7));
        end

        // Load 0,0,1,1 -> en, inv, level
        do_reset();
        trig_in = 1'b0;
        load_bits(4, 8'b0000_1100);
        tick(); chk("s2_hit_a", int'(hit0), 0);
        tick(); chk("s2_hit_b", int'(hit0), 1);
        trig_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("s2_hit_c", int'(hit0), int'(i < 4));
        end

        // Glitch filter: 3-cycle pulse blocked by FILTER_CYC=4, 4-cycle pulse passes
        do_reset();
        trig_in = 1'b0;
        repeat (3) tick();
        c0 = 0; c1 = 0;
        trig_in = 1'b1;
        repeat (3) begin tick(); c0 += int'(hit0); c1 += int'(hit1); end
        trig_in = 1'b0;
        repeat (14) begin tick(); c0 += int'(hit0); c1 += int'(hit1); end
        chk("s3_short_cnt0", c0, 1);
        chk("s3_short_cnt4", c1, 0);
        c0 = 0; c1 = 0;
        trig_in = 1'b1;
        repeat (4) begin tick(); c0 += int'(hit0); c1 += int'(hit1); end
        trig_in = 1'b0;
        repeat (14) begin tick(); c0 += int'(hit0); c1 += int'(hit1); end
        chk("s3_long_cnt0", c0, 1);
        chk("s3_long_cnt4", c1, 1);

        // Any-edge mode: two pulses 10 cycles apart
        do_reset();
        trig_in = 1'b0;
        load_bits(4, 8'b0000_1011);
        repeat (2) tick();
        pos0.delete(); pos1.delete();
        for (int t = 0; t < 25; t++) begin
            trig_in = (t < 10);
            tick();
            if (hit0) pos0.push_back(t);
            if (hit1) pos1.push_back(t);
        end
        chk("s4_npulse0", pos0.size(), 2);
        chk("s4_npulse4", pos1.size(), 2);
        chk("s4_gap0", (pos0.size() >= 2) ? pos0[1] - pos0[0] : -1, 10);
        chk("s4_gap4", (pos1.size() >= 2) ? pos1[1] - pos1[0] : -1, 10);

        // Readback after reset, then a non-matching ID
        do_reset();
        trig_in = 1'b0;
        read_word(w, lb);
        chk("s5_word", int'(w), int'(4'b1001));
        chk("s5_last", int'(lb), int'(4'b1000));
        conf_sel_rd = 1'b1; conf_id = 5'd3;
        #2;
        chk("s5_wrongid_rdata", int'(rdata0), 0);
        chk("s5_wrongid_rdlast", int'(rdlast0), 0);
        tick();
        conf_sel_rd = 1'b0; conf_id = 5'd0;

        // Reset while level-mode hit is high restores the initial word
        load_bits(4, 8'b0000_1000);
        trig_in = 1'b1;
        repeat (5) tick();
        chk("s6_hit_pre", int'(hit0), 1);
        do_reset();
        read_word(w, lb);
        chk("s6_word", int'(w), int'(INIT));

        // Steady-state vector table
        do_reset();
        for (int k = 0; k < 9; k++) begin
            load_bits(4, {4'b0000, tbl[k].cfg});
            trig_in = tbl[k].tin;
            repeat (12) tick();
            chk("tbl_hit0", int'(hit0), int'(tbl[k].exp_hit));
            chk("tbl_hit4", int'(hit1), int'(tbl[k].exp_hit));
            read_word(w, lb);
            chk("tbl_word", int'(w), int'(tbl[k].cfg));
            chk("tbl_last", int'(lb), int'(4'b1000));
        end

        // Randomized traffic against the model
        do_reset();
        run_left = 0;
        for (int t = 0; t < 2500; t++) begin
            if (run_left == 0) begin
                trig_in  = 1'($urandom_range(0, 1));
                run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                       : int'($urandom_range(1, 10));
            end
            run_left--;
            conf_sel_rd = ($urandom_range(0, 3) != 0);
            conf_id     = ($urandom_range(0, 3) == 0) ? 5'd3 : 5'd0;
            conf_rden   = 1'($urandom_range(0, 1));
            conf_sel    = ($urandom_range(0, 29) == 0);
            shift_i     = 1'($urandom_range(0, 1));
            conf_tdi    = 1'($urandom_range(0, 1));
            if (t == 1200) do_reset();
            if ($urandom_range(0, 79) == 0)
                load_bits(int'($urandom_range(3, 6)), 8'($urandom));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
